// File: rtl/ex_stage.sv
// ex_stage: execute stage with combinational ALU, single-cycle multiply and a serial restoring divider.
// Define EX_OVERFLOW_TRAP_EN to flag signed overflow on ADD/SUB and suppress their register write.
module ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int OP_WIDTH   = 8,
    parameter int CAT_WIDTH  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [OP_WIDTH-1:0]   ex_operator,
    input  logic [CAT_WIDTH-1:0]  ex_category,
    input  logic [DATA_WIDTH-1:0] ex_operand1,
    input  logic [DATA_WIDTH-1:0] ex_operand2,
    input  logic [ADDR_WIDTH-1:0] ex_write_addr,
    input  logic                  ex_write_enable,
    input  logic [DATA_WIDTH-1:0] ex_return_target,
    input  logic                  ex_is_curr_in_delayslot,
    input  logic [DATA_WIDTH-1:0] hi_in,
    input  logic [DATA_WIDTH-1:0] lo_in,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  write_enable,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  hilo_write_enable,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out,
    output logic                  is_in_delayslot,
    output logic                  overflow,
    output logic                  stall_request
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(8'h24), OP_OR = OP_WIDTH'(8'h25);
    localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(8'h26), OP_NOR = OP_WIDTH'(8'h27);
    localparam logic [OP_WIDTH-1:0] OP_SLL = OP_WIDTH'(8'h7C), OP_SRL = OP_WIDTH'(8'h02);
    localparam logic [OP_WIDTH-1:0] OP_SRA = OP_WIDTH'(8'h03), OP_ADD = OP_WIDTH'(8'h20);
    localparam logic [OP_WIDTH-1:0] OP_ADDU = OP_WIDTH'(8'h21), OP_SUB = OP_WIDTH'(8'h22);
    localparam logic [OP_WIDTH-1:0] OP_SUBU = OP_WIDTH'(8'h23), OP_SLT = OP_WIDTH'(8'h2A);
    localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(8'h2B), OP_MFHI = OP_WIDTH'(8'h10);
    localparam logic [OP_WIDTH-1:0] OP_MTHI = OP_WIDTH'(8'h11), OP_MFLO = OP_WIDTH'(8'h12);
    localparam logic [OP_WIDTH-1:0] OP_MTLO = OP_WIDTH'(8'h13), OP_MULT = OP_WIDTH'(8'h18);
    localparam logic [OP_WIDTH-1:0] OP_MULTU = OP_WIDTH'(8'h19), OP_DIV = OP_WIDTH'(8'h1A);
    localparam logic [OP_WIDTH-1:0] OP_DIVU = OP_WIDTH'(8'h1B);
    localparam logic [CAT_WIDTH-1:0] CAT_LOGIC = CAT_WIDTH'(1), CAT_SHIFT = CAT_WIDTH'(2);
    localparam logic [CAT_WIDTH-1:0] CAT_MOVE = CAT_WIDTH'(3), CAT_ARITH = CAT_WIDTH'(4);
    localparam logic [CAT_WIDTH-1:0] CAT_JUMP = CAT_WIDTH'(5);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} div_state_t;

    div_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d;
    logic [DW-1:0]   a, b, sum, diff, alu_res, wd, hi_v, lo_v, div_quo, div_rem;
    logic [2*DW-1:0] prod;
    logic [DW:0]     shifted, trial;
    logic            is_div, is_sdiv, is_mult, hwe, ovf;

    assign a       = ex_operand1;
    assign b       = ex_operand2;
    assign sum     = a + b;
    assign diff    = a - b;
    assign is_div  = ex_operator == OP_DIV || ex_operator == OP_DIVU;
    assign is_sdiv = ex_operator == OP_DIV;
    assign is_mult = ex_operator == OP_MULT;
    // Sign-extending both operands makes the low 2*DW bits of an unsigned multiply the signed product.
    assign prod    = {{DW{a[DW-1] & is_mult}}, a} * {{DW{b[DW-1] & is_mult}}, b};
`ifdef EX_OVERFLOW_TRAP_EN
    assign ovf = (ex_operator == OP_ADD && a[DW-1] == b[DW-1] && sum[DW-1] != a[DW-1]) ||
                 (ex_operator == OP_SUB && a[DW-1] != b[DW-1] && diff[DW-1] != a[DW-1]);
`else
    assign ovf = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        case (ex_operator)
            OP_AND:           alu_res = a & b;
            OP_OR:            alu_res = a | b;
            OP_XOR:           alu_res = a ^ b;
            OP_NOR:           alu_res = ~(a | b);
            OP_SLL:           alu_res = a << b[4:0];
            OP_SRL:           alu_res = a >> b[4:0];
            OP_SRA:           alu_res = $unsigned($signed(a) >>> b[4:0]);
            OP_ADD, OP_ADDU:  alu_res = sum;
            OP_SUB, OP_SUBU:  alu_res = diff;
            OP_SLT:           alu_res = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:          alu_res = {{(DW-1){1'b0}}, a < b};
            default:          alu_res = '0;
        endcase
    end

    assign shifted = {rem_q, quo_q[DW-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign div_quo = qneg_q ? -quo_q : quo_q;
    assign div_rem = rneg_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        if (flush) begin
            state_d = S_FREE;
        end else begin
            case (state_q)
                S_FREE: if (is_div) begin
                    state_d = b == '0 ? S_BYZERO : S_ON;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = is_sdiv && a[DW-1] ? -a : a;
                    dvs_d   = is_sdiv && b[DW-1] ? -b : b;
                    qneg_d  = is_sdiv && (a[DW-1] ^ b[DW-1]);
                    rneg_d  = is_sdiv && a[DW-1];
                end
                S_BYZERO: begin
                    state_d = S_END;
                    rem_d   = '0;
                    quo_d   = '0;
                end
                S_ON: begin
                    cnt_d   = cnt_q + 1'b1;
                    rem_d   = trial[DW] ? shifted[DW-1:0] : trial[DW-1:0];
                    quo_d   = {quo_q[DW-2:0], ~trial[DW]};
                    state_d = cnt_q == CW'(DW - 1) ? S_END : S_ON;
                end
                default: state_d = S_FREE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FREE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    always_comb begin
        wd   = ex_category == CAT_LOGIC || ex_category == CAT_SHIFT || ex_category == CAT_ARITH ? alu_res :
               ex_category == CAT_MOVE ? (ex_operator == OP_MFHI ? hi_in : ex_operator == OP_MFLO ? lo_in : '0) :
               ex_category == CAT_JUMP ? ex_return_target : '0;
        hwe  = 1'b0;
        hi_v = hi_in;
        lo_v = lo_in;
        if (state_q == S_END && !flush) begin
            hwe  = 1'b1;
            hi_v = div_rem;
            lo_v = div_quo;
        end else if (ex_operator == OP_MTHI) begin
            hwe  = 1'b1;
            hi_v = a;
        end else if (ex_operator == OP_MTLO) begin
            hwe  = 1'b1;
            lo_v = a;
        end else if (is_mult || ex_operator == OP_MULTU) begin
            hwe  = 1'b1;
            {hi_v, lo_v} = prod;
        end
    end

    assign write_addr        = reset ? ex_write_addr : '0;
    assign write_enable      = reset & ex_write_enable & ~ovf;
    assign write_data        = reset ? wd : '0;
    assign hilo_write_enable = reset & hwe;
    assign hi_out            = reset ? hi_v : '0;
    assign lo_out            = reset ? lo_v : '0;
    assign is_in_delayslot   = reset & ex_is_curr_in_delayslot;
    assign overflow          = reset & ovf;
    assign stall_request     = reset & ~flush & is_div & (state_q != S_END);
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: vector table, randomized ALU ops against a model, and divider sequences.
module tb_ex_stage;
    localparam logic [7:0] AND_ = 8'h24, OR_ = 8'h25, XOR_ = 8'h26, NOR_ = 8'h27;
    localparam logic [7:0] SLL = 8'h7C, SRL = 8'h02, SRA = 8'h03, ADD = 8'h20, ADDU = 8'h21;
    localparam logic [7:0] SUB = 8'h22, SUBU = 8'h23, SLT = 8'h2A, SLTU = 8'h2B;
    localparam logic [7:0] MFHI = 8'h10, MTHI = 8'h11, MFLO = 8'h12, MTLO = 8'h13;
    localparam logic [7:0] MULT = 8'h18, MULTU = 8'h19, DIV = 8'h1A, DIVU = 8'h1B;

    logic        clock = 0, reset = 0, flush = 0;
    logic [7:0]  ex_operator = 0;
    logic [2:0]  ex_category = 0;
    logic [31:0] ex_operand1 = 0, ex_operand2 = 0, ex_return_target = 32'h1234;
    logic [4:0]  ex_write_addr = 5'd7;
    logic        ex_write_enable = 1, ex_is_curr_in_delayslot = 1;
    logic [31:0] hi_in = 32'hAAAA0000, lo_in = 32'h0000BBBB;
    logic [4:0]  write_addr;
    logic        write_enable, hilo_write_enable, is_in_delayslot, overflow, stall_request;
    logic [31:0] write_data, hi_out, lo_out;
    int checks = 0, failures = 0;

    ex_stage dut (
        .clock(clock), .reset(reset), .flush(flush),
        .ex_operator(ex_operator), .ex_category(ex_category),
        .ex_operand1(ex_operand1), .ex_operand2(ex_operand2),
        .ex_write_addr(ex_write_addr), .ex_write_enable(ex_write_enable),
        .ex_return_target(ex_return_target), .ex_is_curr_in_delayslot(ex_is_curr_in_delayslot),
        .hi_in(hi_in), .lo_in(lo_in),
        .write_addr(write_addr), .write_enable(write_enable), .write_data(write_data),
        .hilo_write_enable(hilo_write_enable), .hi_out(hi_out), .lo_out(lo_out),
        .is_in_delayslot(is_in_delayslot), .overflow(overflow), .stall_request(stall_request)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  cat;
        logic [31:0] a, b, wd;
        logic        we, hwe;
        logic [31:0] hi, lo;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [31:0] wd, hi, lo;
        logic        we, hwe, ov;
    } exp_t;

    typedef struct {
        logic [7:0] op;
        logic [2:0] cat;
    } oc_t;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] op, input logic [2:0] cat, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] r;
        longint pa, pb, s;
        logic [63:0] p;
        e = '{wd: 0, hi: 0, lo: 0, we: 0, hwe: 0, ov: 0};
        r = 0;
        pa = $signed(a);
        pb = $signed(b);
        case (op)
            AND_: r = a & b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            NOR_: r = ~(a | b);
            SLL:  r = a << b[4:0];
            SRL:  r = a >> b[4:0];
            SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ADD, ADDU: r = a + b;
            SUB, SUBU: r = a - b;
            SLT:  r = pa < pb ? 1 : 0;
            SLTU: r = a < b ? 1 : 0;
            MTHI: begin e.hwe = 1; e.hi = a; e.lo = lo_in; end
            MTLO: begin e.hwe = 1; e.hi = hi_in; e.lo = a; end
            MULT: begin p = pa * pb; e.hwe = 1; e.hi = p[63:32]; e.lo = p[31:0]; end
            MULTU: begin p = {32'b0, a} * {32'b0, b}; e.hwe = 1; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: r = 0;
        endcase
`ifdef EX_OVERFLOW_TRAP_EN
        s = op == ADD ? pa + pb : pa - pb;
        e.ov = (op == ADD || op == SUB) && (s > 64'sd2147483647 || s < -64'sd2147483648);
`endif
        e.wd = (cat == 1 || cat == 2 || cat == 4) ? r :
               cat == 3 ? (op == MFHI ? hi_in : op == MFLO ? lo_in : 0) :
               cat == 5 ? ex_return_target : 0;
        e.we = ex_write_enable & ~e.ov;
        return e;
    endfunction

    task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input int ecyc);
        int n;
        @(negedge clock);
        ex_operator = op;
        ex_category = 0;
        ex_operand1 = a;
        ex_operand2 = b;
        n = 0;
        #1;
        while (stall_request === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
            #1;
        end
        check({name, " stall_cycles"}, n, ecyc);
        check({name, " hilo_we"}, hilo_write_enable, 1);
        check({name, " quotient"}, lo_out, eq);
        check({name, " remainder"}, hi_out, er);
    endtask

    vec_t tbl[16];
    oc_t  ops[20];

    initial begin
        tbl[0]  = '{OR_,  1, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1, 0, 0, 0, 0};
        tbl[1]  = '{SRA,  2, 32'h80000000, 32'd4, 32'hF8000000, 1, 0, 0, 0, 0};
        tbl[2]  = '{SLT,  4, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 0, 0, 0, 0};
        tbl[3]  = '{SLTU, 4, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0, 0, 0, 0};
        tbl[4]  = '{MULT, 0, 32'hFFFFFFFE, 32'd3, 32'd0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0};
        tbl[5]  = '{MULTU, 0, 32'hFFFFFFFE, 32'd3, 32'd0, 1, 1, 32'h2, 32'hFFFFFFFA, 0};
        tbl[6]  = '{MFHI, 3, 32'd5, 32'd6, 32'hAAAA0000, 1, 0, 0, 0, 0};
        tbl[7]  = '{MFLO, 3, 32'd5, 32'd6, 32'h0000BBBB, 1, 0, 0, 0, 0};
        tbl[8]  = '{MTHI, 0, 32'h11, 32'd0, 32'd0, 1, 1, 32'h11, 32'h0000BBBB, 0};
        tbl[9]  = '{MTLO, 0, 32'h22, 32'd0, 32'd0, 1, 1, 32'hAAAA0000, 32'h22, 0};
        tbl[10] = '{8'h00, 5, 32'd1, 32'd2, 32'h1234, 1, 0, 0, 0, 0};
        tbl[11] = '{NOR_, 1, 32'd0, 32'd0, 32'hFFFFFFFF, 1, 0, 0, 0, 0};
        tbl[12] = '{8'hFF, 1, 32'd3, 32'd4, 32'd0, 1, 0, 0, 0, 0};
        tbl[13] = '{SLL,  2, 32'd1, 32'd35, 32'd8, 1, 0, 0, 0, 0};
`ifdef EX_OVERFLOW_TRAP_EN
        tbl[14] = '{ADD,  4, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 0, 0, 0, 1};
`else
        tbl[14] = '{ADD,  4, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1, 0, 0, 0, 0};
`endif
        tbl[15] = '{SUBU, 4, 32'd0, 32'd1, 32'hFFFFFFFF, 1, 0, 0, 0, 0};
        ops = '{'{AND_, 1}, '{OR_, 1}, '{XOR_, 1}, '{NOR_, 1}, '{SLL, 2}, '{SRL, 2}, '{SRA, 2},
                '{ADD, 4}, '{ADDU, 4}, '{SUB, 4}, '{SUBU, 4}, '{SLT, 4}, '{SLTU, 4},
                '{MFHI, 3}, '{MFLO, 3}, '{MTHI, 0}, '{MTLO, 0}, '{MULT, 0}, '{MULTU, 0}, '{8'h00, 5}};

        #2;
        check("reset outputs", {write_addr, write_enable, write_data, hilo_write_enable, hi_out, lo_out,
                                is_in_delayslot, overflow, stall_request}, 0);
        @(negedge clock);
        reset = 1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            ex_operator = tbl[i].op;
            ex_category = tbl[i].cat;
            ex_operand1 = tbl[i].a;
            ex_operand2 = tbl[i].b;
            #1;
            check($sformatf("vec%0d write_data", i), write_data, tbl[i].wd);
            check($sformatf("vec%0d write_enable", i), write_enable, tbl[i].we);
            check($sformatf("vec%0d hilo_we", i), hilo_write_enable, tbl[i].hwe);
            check($sformatf("vec%0d overflow", i), overflow, tbl[i].ov);
            check($sformatf("vec%0d addr_ds", i), {write_addr, is_in_delayslot, stall_request}, {5'd7, 1'b1, 1'b0});
            if (tbl[i].hwe) check($sformatf("vec%0d hilo", i), {hi_out, lo_out}, {tbl[i].hi, tbl[i].lo});
        end

        for (int i = 0; i < 200; i++) begin
            oc_t  o;
            exp_t e;
            o = ops[$urandom_range(0, 19)];
            @(negedge clock);
            ex_operator = o.op;
            ex_category = o.cat;
            ex_operand1 = $urandom;
            ex_operand2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            e = model(o.op, o.cat, ex_operand1, ex_operand2);
            #1;
            check($sformatf("rnd op%0h write_data", o.op), write_data, e.wd);
            check($sformatf("rnd op%0h write_enable", o.op), write_enable, e.we);
            check($sformatf("rnd op%0h hilo_we", o.op), hilo_write_enable, e.hwe);
            check($sformatf("rnd op%0h overflow", o.op), overflow, e.ov);
            if (e.hwe) check($sformatf("rnd op%0h hilo", o.op), {hi_out, lo_out}, {e.hi, e.lo});
        end

        run_div("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        run_div("divu 7/0", DIVU, 32'd7, 32'd0, 32'd0, 32'd0, 2);

        @(negedge clock);
        ex_operator = DIVU;
        ex_operand1 = 32'd100;
        ex_operand2 = 32'd7;
        repeat (10) @(negedge clock);
        flush = 1;
        #1;
        check("flush stall", stall_request, 0);
        check("flush hilo_we", hilo_write_enable, 0);
        @(negedge clock);
        flush = 0;
        ex_operator = 0;
        #1;
        check("post-flush stall", stall_request, 0);
        check("post-flush hilo_we", hilo_write_enable, 0);
        run_div("divu 9/2 after flush", DIVU, 32'd9, 32'd2, 32'd4, 32'd1, 33);

        @(negedge clock);
        ex_operator = DIVU;
        ex_operand1 = 32'd100;
        ex_operand2 = 32'd7;
        repeat (5) @(negedge clock);
        reset = 0;
        ex_operator = 0;
        #1;
        check("mid-div reset outputs", {write_addr, write_enable, write_data, hilo_write_enable, hi_out, lo_out,
                                        is_in_delayslot, overflow, stall_request}, 0);
        @(negedge clock);
        reset = 1;
        run_div("divu 100/7 after reset", DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33);

        for (int i = 0; i < 20; i++) begin
            logic [7:0]  op;
            logic [31:0] a, b, q, r;
            int          sa, sb;
            op = (i % 2 == 0) ? DIV : DIVU;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 1000)));
            if (op == DIV && a == 32'h80000000) a = 32'h80000001;
            sa = a;
            sb = b;
            q = b == 0 ? 0 : op == DIV ? 32'(sa / sb) : a / b;
            r = b == 0 ? 0 : op == DIV ? 32'(sa % sb) : a % b;
            run_div($sformatf("rnd div%0d", i), op, a, b, q, r, b == 0 ? 2 : 33);
        end
        @(negedge clock);
        ex_operator = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
